inner_dot_mode_acc: RTL and testbench

//  Parametrised successor of the conv/FC dot-product selector. It picks per-group between
//  the conv and FC operand sets and computes a signed LANES-wide inner product through a
//  3-stage pipeline. In FC mode it accumulates a runtime-set number of beats before emitting
//  one result. Sits between the operand line buffers and the requant/activation stage.

---
 rtl/inner_dot_mode_acc_pkg.sv | 22 ++
 rtl/inner_dot_mode_acc_if.sv | 32 +++
 rtl/inner_dot_mode_acc_dot_prod_tree.sv | 62 ++++++
 rtl/inner_dot_mode_acc.sv | 147 ++++++++++++++
 tb/tb_inner_dot_mode_acc.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/inner_dot_mode_acc_pkg.sv
// Shared constants, grouping-FSM state type and width helpers for the
// conv/FC inner-product block.
package inner_dot_pkg;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_FC   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } grp_state_t;

  function automatic int prod_width(input int dw);
    return 2 * dw;
  endfunction

  // Smallest result width that can hold a full beat without wrapping.
  function automatic int sum_min_width(input int lanes, input int dw);
    return 2 * dw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/inner_dot_mode_acc_if.sv
// Operand-in / dot-out handshake bundle; the block is the slave, the
// line buffers and requant stage together form the master side.
interface inner_dot_mode_acc_if #(
  parameter int LANES     = 9,
  parameter int DW        = 8,
  parameter int SUM_WIDTH = 21,
  parameter int LEN_W     = 7
);
  logic                 mode;
  logic [LEN_W-1:0]     acc_len;
  logic                 in_vld;
  logic                 in_rdy;
  logic [LANES*DW-1:0]  data_conv;
  logic [LANES*DW-1:0]  weight_conv;
  logic [LANES*DW-1:0]  data_fc;
  logic [LANES*DW-1:0]  weight_fc;
  logic                 out_vld;
  logic                 out_rdy;
  logic [SUM_WIDTH-1:0] dot;
  logic                 out_mode;
  logic                 ovf;

  modport slave (
    input  mode, acc_len, in_vld, data_conv, weight_conv, data_fc, weight_fc, out_rdy,
    output in_rdy, out_vld, dot, out_mode, ovf
  );

  modport master (
    output mode, acc_len, in_vld, data_conv, weight_conv, data_fc, weight_fc, out_rdy,
    input  in_rdy, out_vld, dot, out_mode, ovf
  );
endinterface

// File: rtl/inner_dot_mode_acc_dot_prod_tree.sv
// S1 lane multipliers and S2 sign-extended adder tree; a side-band tag
// rides along with the valid so the caller can mark group boundaries.
module dot_prod_tree
  import inner_dot_pkg::*;
#(
  parameter int LANES     = 9,
  parameter int DW        = 8,
  parameter int SUM_WIDTH = 21,
  parameter int TAG_W     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adv,
  input  logic                        in_vld,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [LANES*DW-1:0]         data,
  input  logic [LANES*DW-1:0]         weight,
  output logic                        out_vld,
  output logic [TAG_W-1:0]            out_tag,
  output logic signed [SUM_WIDTH-1:0] out_sum
);

  localparam int PW = prod_width(DW);

  logic signed [PW-1:0]        prod_q [LANES];
  logic                        vld1_q;
  logic [TAG_W-1:0]            tag1_q;
  logic signed [SUM_WIDTH-1:0] tree_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      tag1_q <= '0;
      // NOTE: the product registers are a handful of flops, not a RAM, so
      // they share the reset and never carry X into the tree.
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (adv) begin
      vld1_q <= in_vld;
      tag1_q <= in_tag;
      for (int i = 0; i < LANES; i++)
        prod_q[i] <= $signed(data[i*DW +: DW]) * $signed(weight[i*DW +: DW]);
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum += SUM_WIDTH'(prod_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_tag <= '0;
      out_sum <= '0;
    end else if (adv) begin
      out_vld <= vld1_q;
      out_tag <= tag1_q;
      out_sum <= tree_sum;
    end
  end

endmodule

// File: rtl/inner_dot_mode_acc.sv
// Conv/FC operand select, grouping FSM, S3 accumulator and output handshake.
// Optional build macro DOT_SAT_EN: saturating accumulate with sticky ovf.
module inner_dot_mode_acc
  import inner_dot_pkg::*;
#(
  parameter int LANES     = 9,
  parameter int DW        = 8,
  parameter int SUM_WIDTH = 21,
  parameter int LEN_W     = 7
) (
  input logic                   clk,
  input logic                   rst_n,
  inner_dot_mode_acc_if.slave   bus
);

  logic adv, accept;
  logic out_vld_q, out_mode_q;
  logic signed [SUM_WIDTH-1:0] dot_q;

  // One global stall: nothing moves while a finished dot is waiting.
  assign adv        = !(out_vld_q && !bus.out_rdy);
  assign accept     = bus.in_vld && adv;
  assign bus.in_rdy = adv;

  grp_state_t          state_q;
  logic [LEN_W-1:0]    cnt_q, len_q;
  logic                mode_q;
  logic                is_first, is_last, cur_mode;
  logic [LANES*DW-1:0] data_sel, weight_sel;

  always_comb begin
    // NOTE: every output is assigned on every path so no latch is inferred.
    is_first   = (state_q == IDLE);
    cur_mode   = is_first ? bus.mode : mode_q;
    is_last    = is_first ? (bus.mode == MODE_CONV || bus.acc_len <= LEN_W'(1))
                          : (cnt_q == len_q - LEN_W'(1));
    data_sel   = (cur_mode == MODE_FC) ? bus.data_fc   : bus.data_conv;
    weight_sel = (cur_mode == MODE_FC) ? bus.weight_fc : bus.weight_conv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_CONV;
    end else if (accept) begin
      // NOTE: state registers use nonblocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      case (state_q)
        IDLE: if (!is_last) begin
          state_q <= ACC;
          cnt_q   <= LEN_W'(1);
          len_q   <= bus.acc_len;
          mode_q  <= bus.mode;
        end
        ACC: if (is_last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q   <= cnt_q + LEN_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic                        vld2, first2, last2, mode2;
  logic [2:0]                  tag2;
  logic signed [SUM_WIDTH-1:0] sum2;

  dot_prod_tree #(
    .LANES(LANES), .DW(DW), .SUM_WIDTH(SUM_WIDTH), .TAG_W(3)
  ) u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (adv),
    .in_vld (accept),
    .in_tag ({is_first, is_last, cur_mode}),
    .data   (data_sel),
    .weight (weight_sel),
    .out_vld(vld2),
    .out_tag(tag2),
    .out_sum(sum2)
  );

  assign {first2, last2, mode2} = tag2;

  logic signed [SUM_WIDTH-1:0] acc_q, acc_base, acc_next;

  // A first-tagged beat adds onto zero, which makes it a clean load.
  assign acc_base = first2 ? '0 : acc_q;

`ifdef DOT_SAT_EN
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  logic                      sat_q, sat_next, ovf_q;
  logic signed [SUM_WIDTH:0] wide_sum;

  always_comb begin
    wide_sum = (SUM_WIDTH+1)'(acc_base) + (SUM_WIDTH+1)'(sum2);
    acc_next = wide_sum[SUM_WIDTH-1:0];
    sat_next = first2 ? 1'b0 : sat_q;
    if (wide_sum[SUM_WIDTH] != wide_sum[SUM_WIDTH-1]) begin
      acc_next = wide_sum[SUM_WIDTH] ? SAT_MIN : SAT_MAX;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (adv && vld2) begin
      sat_q <= sat_next;
      if (last2) ovf_q <= sat_next;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign acc_next = acc_base + sum2;
  assign bus.ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      out_vld_q  <= 1'b0;
      dot_q      <= '0;
      out_mode_q <= MODE_CONV;
    end else if (adv) begin
      out_vld_q <= vld2 && last2;
      if (vld2) acc_q <= acc_next;
      if (vld2 && last2) begin
        dot_q      <= acc_next;
        out_mode_q <= mode2;
      end
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.dot      = dot_q;
  assign bus.out_mode = out_mode_q;

endmodule

// File: tb/tb_inner_dot_mode_acc.sv
// Directed bench for inner_dot_mode_acc: conv, FC accumulate, stall,
// mode-change immunity, bubbles, short FC groups, reset and wrap/saturation.
module tb_inner_dot_mode_acc;

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int SW    = 21;
  localparam int LEN_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  inner_dot_mode_acc_if #(.LANES(LANES), .DW(DW), .SUM_WIDTH(SW), .LEN_W(LEN_W)) bus ();

  inner_dot_mode_acc #(.LANES(LANES), .DW(DW), .SUM_WIDTH(SW), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [LANES*DW-1:0] fill(input int v);
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge, then presents one input cycle.
  task automatic beat(input logic v, input logic m, input int len,
                      input int dc, input int wc, input int df, input int wf);
    @(negedge clk);
    bus.in_vld      = v;
    bus.mode        = m;
    bus.acc_len     = LEN_W'(len);
    bus.data_conv   = fill(dc);
    bus.weight_conv = fill(wc);
    bus.data_fc     = fill(df);
    bus.weight_fc   = fill(wf);
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_out(input string tag, input logic vld,
                           input int d, input logic m);
    check({tag, "_vld"}, bus.out_vld, vld);
    check({tag, "_dot"}, $signed(bus.dot), d);
    check({tag, "_mode"}, bus.out_mode, m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b0;
    bus.mode    = 1'b0;
    bus.acc_len = '0;
    bus.data_conv = '0; bus.weight_conv = '0; bus.data_fc = '0; bus.weight_fc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_out("reset", 1'b0, 0, 1'b0);
    check("reset_ovf", bus.ovf, 1'b0);
    check("reset_in_rdy", bus.in_rdy, 1'b1);

    // Conv single beat: 9 lanes * 1 * 2 = 18, visible three cycles later.
    bus.out_rdy = 1'b1;
    beat(1'b1, 1'b0, 1, 1, 2, 7, 7);
    idle(); check("conv_lat1_vld", bus.out_vld, 1'b0);
    idle(); check("conv_lat2_vld", bus.out_vld, 1'b0);
    idle(); check_out("conv_t3", 1'b1, 18, 1'b0);
    check("conv_ovf", bus.ovf, 1'b0);
    idle(); check("conv_after_vld", bus.out_vld, 1'b0);

    // Back-to-back conv beats: weights 1,2,3 -> 9,18,27 on consecutive clocks.
    for (int c = 0; c < 6; c++) begin
      if (c < 3) beat(1'b1, 1'b0, 1, 1, c + 1, 7, 7); else idle();
      if (c >= 3) check_out("b2b", 1'b1, 9 * (c - 2), 1'b0);
    end

    // FC acc_len=4, -3*5*9 = -135 per beat -> -540 after the 4th beat.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) beat(1'b1, 1'b1, 4, 1, 1, -3, 5); else idle();
      if (c == 4 || c == 5) check("fc_wait_vld", bus.out_vld, 1'b0);
      if (c == 6) check_out("fc4", 1'b1, -540, 1'b1);
      if (c == 7) check("fc_after_vld", bus.out_vld, 1'b0);
    end

    // Stall with three conv beats in flight; a beat offered during the
    // stall must be refused, and the release drains 9,18,27 in order.
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c < 3)       beat(1'b1, 1'b0, 1, 1, c + 1, 0, 0);
      else if (c == 3) beat(1'b1, 1'b0, 1, 1, 5, 0, 0);
      else             idle();
      if (c >= 3 && c <= 5) begin
        check("stall_in_rdy", bus.in_rdy, 1'b0);
        check_out("stall_hold", 1'b1, 9, 1'b0);
      end
      if (c == 6) bus.out_rdy = 1'b1;
      if (c == 7) check_out("stall_rel1", 1'b1, 18, 1'b0);
      if (c == 8) check_out("stall_rel2", 1'b1, 27, 1'b0);
      if (c >= 9) check("stall_drained_vld", bus.out_vld, 1'b0);
    end

    // Mode/len change on beat 2 of an FC len=3 group is ignored:
    // 54 + 9 + 54 = 117 from the FC set.
    for (int c = 0; c < 7; c++) begin
      if (c == 0 || c == 2) beat(1'b1, 1'b1, 3, 4, 4, 2, 3);
      else if (c == 1)      beat(1'b1, 1'b0, 1, 4, 4, 1, 1);
      else                  idle();
      if (c == 3 || c == 4) check("modechg_wait_vld", bus.out_vld, 1'b0);
      if (c == 5) check_out("modechg", 1'b1, 117, 1'b1);
      if (c == 6) check("modechg_after_vld", bus.out_vld, 1'b0);
    end

    // FC len=2 with a bubble carrying junk data between the beats -> 9+9.
    for (int c = 0; c < 6; c++) begin
      if (c == 0 || c == 2) beat(1'b1, 1'b1, 2, 0, 0, 1, 1);
      else if (c == 1)      beat(1'b0, 1'b1, 2, 0, 0, 9, 9);
      else                  idle();
      if (c == 4) check("bubble_wait_vld", bus.out_vld, 1'b0);
      if (c == 5) check_out("bubble", 1'b1, 18, 1'b1);
    end

    // FC with acc_len 0 then 1: each beat is its own group, out_mode=1.
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      beat(1'b1, 1'b1, 0, 3, 3, 1, 2);
      else if (c == 1) beat(1'b1, 1'b1, 1, 3, 3, 1, 3);
      else             idle();
      if (c == 3) check_out("fc_len0", 1'b1, 18, 1'b1);
      if (c == 4) check_out("fc_len1", 1'b1, 27, 1'b1);
    end

    // Reset after two beats of an FC group, then a fresh conv beat -> 9.
    beat(1'b1, 1'b1, 4, 1, 1, -3, 5);
    beat(1'b1, 1'b1, 4, 1, 1, -3, 5);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_vld = 1'b0;
    #1;
    check_out("midrst", 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 1'b0, 1, 1, 1, 5, 5);
    idle(); idle();
    check("post_rst_wait_vld", bus.out_vld, 1'b0);
    idle();
    check_out("post_rst", 1'b1, 9, 1'b0);

    // FC len=127 of (-128)*(-128)*9 = 147456 per beat.
    for (int c = 0; c < 131; c++) begin
      if (c < 127) beat(1'b1, 1'b1, 127, 0, 0, -128, -128); else idle();
      if (c == 128) check("big_wait_vld", bus.out_vld, 1'b0);
      if (c == 129) begin
`ifdef DOT_SAT_EN
        check_out("big_sat", 1'b1, 1048575, 1'b1);
        check("big_sat_ovf", bus.ovf, 1'b1);
`else
        check_out("big_wrap", 1'b1, -147456, 1'b1);
        check("big_wrap_ovf", bus.ovf, 1'b0);
`endif
      end
      if (c == 130) check("big_after_vld", bus.out_vld, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
